// File: rtl/lsu_sb.sv
// rtl/lsu_sb.sv - load/store unit with posted store buffer, chip-enable decode and misalignment drop
// Optional LSU_FWD_EN: word store-to-load forwarding out of the store buffer.
module lsu_sb #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int SB_DEPTH = 4,
  parameter int CE_N     = 8,
  parameter int CE_MSB   = 31,
  parameter int CE_LSB   = 28
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  input  logic            i_WE,
  input  logic            i_RE,
  input  logic [1:0]      i_HB,
  input  logic            i_ULOAD,
  input  logic [AW-1:0]   i_ADDR,
  input  logic [DW-1:0]   i_WDATA,
  output logic [DW-1:0]   o_RDATA,
  output logic            o_STALL,
  output logic            o_MISALIGNED,
  output logic            o_BUS_REQ,
  input  logic            i_BUS_GNT,
  output logic [AW-1:0]   o_BUS_ADDR,
  output logic [DW-1:0]   o_BUS_WDATA,
  output logic            o_BUS_WE,
  output logic            o_BUS_RE,
  output logic [1:0]      o_BUS_HB,
  output logic [CE_N-1:0] o_BUS_CE,
  input  logic [DW-1:0]   i_BUS_RDATA
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, LOAD} state_t;
  state_t state, state_nx;

  logic [AW-1:0]   sb_addr [SB_DEPTH];
  logic [DW-1:0]   sb_data [SB_DEPTH];
  logic [1:0]      sb_hb   [SB_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            mis, full, enq, deq, head_mapped, ld_go, ld_mapped, fwd_hit;
  logic [DW-1:0]   fwd_data;
  logic [CE_N-1:0] head_ce, ld_ce;

  function automatic logic [CE_N-1:0] ce_decode(input logic [AW-1:0] a);
    logic [CE_MSB-CE_LSB:0] f;
    f = a[CE_MSB:CE_LSB];
    for (int i = 0; i < CE_N; i++) ce_decode[i] = (int'(f) == i);
  endfunction

  function automatic logic [DW-1:0] ext(input logic [DW-1:0] d, input logic [1:0] hb, input logic u);
    case (hb)
      2'b00:   ext = {{(DW-8){~u & d[7]}}, d[7:0]};
      2'b01:   ext = {{(DW-16){~u & d[15]}}, d[15:0]};
      default: ext = d;
    endcase
  endfunction

  assign mis          = ~i_RST & (i_WE | i_RE) &
                        ((i_HB == 2'b01 & i_ADDR[0]) | (i_HB[1] & (i_ADDR[1:0] != 2'b00)));
  assign o_MISALIGNED = mis;
  assign full         = (cnt == CW'(SB_DEPTH));
  assign enq          = i_WE & ~mis & ~full;
  assign head_ce      = ce_decode(sb_addr[rd_ptr]);
  assign head_mapped  = |head_ce;
  // Unmapped stores leave the buffer without touching the bus.
  assign deq          = (state == DRAIN) & (~head_mapped | i_BUS_GNT);
  assign ld_ce        = ce_decode(i_ADDR);
  assign ld_mapped    = |ld_ce;
  assign ld_go        = i_RE & ~mis & (cnt == '0);
  assign cnt_nx       = cnt + CW'(enq) - CW'(deq);

`ifdef LSU_FWD_EN
  logic [PW-1:0] fwd_idx;
  // Oldest to newest: the newest store overlapping the word decides; only an exact word store forwards.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      fwd_idx = rd_ptr + PW'(k);
      if (CW'(k) < cnt && sb_addr[fwd_idx][AW-1:2] == i_ADDR[AW-1:2]) begin
        fwd_hit  = sb_hb[fwd_idx][1];
        fwd_data = sb_data[fwd_idx];
      end
    end
    fwd_hit = fwd_hit & i_RE & ~mis & i_HB[1];
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    state_nx    = state;
    o_STALL     = 1'b0;
    o_RDATA     = '0;
    o_BUS_REQ   = 1'b0;
    o_BUS_WE    = 1'b0;
    o_BUS_RE    = 1'b0;
    o_BUS_ADDR  = '0;
    o_BUS_WDATA = '0;
    o_BUS_HB    = '0;
    o_BUS_CE    = '0;
    if (!i_RST) begin
      if (state == DRAIN) begin
        o_BUS_REQ   = head_mapped;
        o_BUS_WE    = head_mapped;
        o_BUS_ADDR  = sb_addr[rd_ptr];
        o_BUS_WDATA = sb_data[rd_ptr];
        o_BUS_HB    = sb_hb[rd_ptr];
        o_BUS_CE    = head_ce;
      end else if (ld_go && ld_mapped) begin
        o_BUS_REQ  = 1'b1;
        o_BUS_RE   = 1'b1;
        o_BUS_ADDR = i_ADDR;
        o_BUS_HB   = i_HB;
        o_BUS_CE   = ld_ce;
      end
      if (i_WE && !mis && full) o_STALL = 1'b1;
      if (fwd_hit) begin
        o_RDATA = fwd_data;
      end else if (i_RE && !mis && cnt != '0) begin
        o_STALL = 1'b1;
      end else if (ld_go && ld_mapped) begin
        if (i_BUS_GNT) o_RDATA = ext(i_BUS_RDATA, i_HB, i_ULOAD);
        else           o_STALL = 1'b1;
      end
      if (ld_go && ld_mapped && !i_BUS_GNT) state_nx = LOAD;
      else                                  state_nx = (cnt_nx != '0) ? DRAIN : IDLE;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state  <= IDLE;
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge i_CLK) begin
    if (enq) begin
      sb_addr[wr_ptr] <= i_ADDR;
      sb_data[wr_ptr] <= i_WDATA;
      sb_hb[wr_ptr]   <= i_HB;
    end
  end
endmodule

// File: tb/tb_lsu_sb.sv
// tb/tb_lsu_sb.sv - scoreboard testbench for lsu_sb (default build, LSU_FWD_EN undefined)
module tb_lsu_sb;
  logic        clk = 1'b0, rst, we, re, uload, gnt, req, bwe, bre, stall, misal;
  logic [1:0]  hb, bhb;
  logic [31:0] addr, wdata, rdata, baddr, bwdata, brdata;
  logic [7:0]  ce;
  int checks = 0, fails = 0, gnt_mode = 1;
  int st;
  logic [31:0] rd;
  bit ms, rq;

  typedef struct packed { logic w; logic [31:0] a; logic [31:0] d; logic [1:0] hb; } xfer_t;
  xfer_t       bus_q[$];
  logic [31:0] rd_q[$];
  logic [7:0]  smem [logic [31:0]];
  logic [7:0]  rmem [logic [31:0]];

  always #5 clk = ~clk;

  lsu_sb dut (
    .i_CLK(clk), .i_RST(rst), .i_WE(we), .i_RE(re), .i_HB(hb), .i_ULOAD(uload),
    .i_ADDR(addr), .i_WDATA(wdata), .o_RDATA(rdata), .o_STALL(stall), .o_MISALIGNED(misal),
    .o_BUS_REQ(req), .i_BUS_GNT(gnt), .o_BUS_ADDR(baddr), .o_BUS_WDATA(bwdata),
    .o_BUS_WE(bwe), .o_BUS_RE(bre), .o_BUS_HB(bhb), .o_BUS_CE(ce), .i_BUS_RDATA(brdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mbyte(input bit slave, input logic [31:0] a);
    if (slave) return smem.exists(a) ? smem[a] : (a[7:0] ^ 8'h5A);
    return rmem.exists(a) ? rmem[a] : (a[7:0] ^ 8'h5A);
  endfunction

  function automatic int nbytes(input logic [1:0] h);
    return (h == 2'b00) ? 1 : (h == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mread(input bit slave, input logic [31:0] a, input logic [1:0] h);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nbytes(h); i++) v[8*i +: 8] = mbyte(slave, a + 32'(i));
    return v;
  endfunction

  function automatic void mwrite(input bit slave, input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] h);
    for (int i = 0; i < nbytes(h); i++) begin
      if (slave) smem[a + 32'(i)] = d[8*i +: 8];
      else       rmem[a + 32'(i)] = d[8*i +: 8];
    end
  endfunction

  function automatic bit misal_of(input logic [1:0] h, input logic [31:0] a);
    return (h == 2'b01 && a[0]) || (h[1] && a[1:0] != 2'b00);
  endfunction

  function automatic bit mapped(input logic [31:0] a);
    return a[31:28] < 4'd8;
  endfunction

  function automatic logic [7:0] ce_of(input logic [31:0] a);
    return mapped(a) ? 8'(1 << a[31:28]) : 8'h0;
  endfunction

  function automatic logic [31:0] ext_of(input logic [31:0] v, input logic [1:0] h, input logic u);
    if (h == 2'b00) return u ? v : 32'($signed(v[7:0]));
    if (h == 2'b01) return u ? v : 32'($signed(v[15:0]));
    return v;
  endfunction

  // Expected responses are queued at issue; the DUT is only observed afterwards.
  task automatic do_op(input bit w, input bit r, input logic [1:0] h, input bit u,
                       input logic [31:0] a, input logic [31:0] d,
                       output int stalls, output logic [31:0] rdv, output bit mis_seen, output bit req_seen);
    bit m = misal_of(h, a);
    if (!m && w && mapped(a)) begin
      bus_q.push_back('{w: 1'b1, a: a, d: d, hb: h});
      mwrite(1'b0, a, d, h);
    end
    if (!m && r) begin
      if (mapped(a)) begin
        bus_q.push_back('{w: 1'b0, a: a, d: 32'h0, hb: h});
        rd_q.push_back(ext_of(mread(1'b0, a, h), h, u));
      end else begin
        rd_q.push_back(32'h0);
      end
    end
    #1;
    we = w; re = r; hb = h; uload = u; addr = a; wdata = d;
    stalls = 0;
    forever begin
      @(negedge clk); #2;
      if (!stall) break;
      stalls++;
      if (stalls > 300) begin
        checks++; fails++;
        $display("FAIL op_timeout: still stalled after %0d cycles, required completion", stalls);
        break;
      end
    end
    rdv = rdata; mis_seen = misal; req_seen = req;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    #1; we = 1'b0; re = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    gnt = 1'b0;
    forever begin
      @(posedge clk); #1;
      gnt = (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : gnt_mode[0];
    end
  end

  // Bus slave plus monitor: drives read data, compares every transfer and every retiring access.
  initial begin
    xfer_t x;
    bit    me;
    brdata = 32'h0;
    forever begin
      @(negedge clk);
      brdata = mread(1'b1, baddr, bhb);
      #1;
      if (!rst) begin
        if (req && gnt) begin
          if (bus_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL bus_unexpected: transfer addr %h we %b, required none", baddr, bwe);
          end else begin
            x = bus_q.pop_front();
            chk("bus_we", 32'(bwe), 32'(x.w));
            chk("bus_re", 32'(bre), 32'(!x.w));
            chk("bus_addr", baddr, x.a);
            chk("bus_hb", 32'(bhb), 32'(x.hb));
            chk("bus_ce", 32'(ce), 32'(ce_of(x.a)));
            if (x.w) begin
              chk("bus_wdata", bwdata, x.d);
              mwrite(1'b1, baddr, bwdata, bhb);
            end
          end
        end
        if ((re || we) && !stall) begin
          me = misal_of(hb, addr);
          chk("misaligned", 32'(misal), 32'(me));
          if (re && me) chk("mis_rdata", rdata, 32'h0);
          if (re && !me) begin
            if (rd_q.size() == 0) begin
              checks++; fails++;
              $display("FAIL load_unexpected: rdata %h, required no load", rdata);
            end else begin
              chk("load_rdata", rdata, rd_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    logic [3:0]  nibs [7] = '{4'h1, 4'h2, 4'h3, 4'h0, 4'h7, 4'h8, 4'hF};
    logic [31:0] a;
    logic [1:0]  h;
    int          r;
    rst = 1'b1; we = 1'b0; re = 1'b0; hb = 2'b00; uload = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_req", 32'(req), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_misal", 32'(misal), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ce", 32'(ce), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk);

    // Single store with grant tied high
    gnt_mode = 1;
    do_op(1, 0, 2'b10, 0, 32'h1000_0004, 32'hDEAD_BEEF, st, rd, ms, rq);
    chk("t1_stall", st, 0);
    #1; we = 1'b0;
    @(negedge clk); #3;
    chk("t1_req", 32'({req, bwe}), 32'b11);
    chk("t1_ce", 32'(ce), 32'h02);
    @(negedge clk); #3;
    chk("t1_drained", 32'(req), 0);
    @(posedge clk);

    // Fill the buffer with grant low; the fifth store waits for the first dequeue
    gnt_mode = 0;
    for (int i = 0; i < 4; i++) begin
      do_op(1, 0, 2'b10, 0, 32'h1000_0010 + 32'(4 * i), $urandom, st, rd, ms, rq);
      chk("t2_nostall", st, 0);
    end
    fork
      do_op(1, 0, 2'b10, 0, 32'h1000_0020, 32'h5555_AAAA, st, rd, ms, rq);
      begin repeat (2) @(posedge clk); gnt_mode = 1; end
    join
    chk("t2_fifth_stall", st, 3);
    idle(8);

    // Byte load sign/zero extension
    smem[32'h2000_0003] = 8'h80;
    rmem[32'h2000_0003] = 8'h80;
    do_op(0, 1, 2'b00, 0, 32'h2000_0003, 0, st, rd, ms, rq);
    chk("t3_lb", rd, 32'hFFFF_FF80);
    chk("t3_latency", st, 0);
    do_op(0, 1, 2'b00, 1, 32'h2000_0003, 0, st, rd, ms, rq);
    chk("t3_lbu", rd, 32'h0000_0080);

    // Load behind two buffered stores
    idle(1);
    gnt_mode = 0;
    do_op(1, 0, 2'b10, 0, 32'h3000_0000, 32'hCAFE_0001, st, rd, ms, rq);
    do_op(1, 0, 2'b10, 0, 32'h3000_0004, 32'hCAFE_0002, st, rd, ms, rq);
    gnt_mode = 1;
    do_op(0, 1, 2'b10, 0, 32'h3000_0000, 0, st, rd, ms, rq);
    chk("t4_stall", st, 2);
    chk("t4_data", rd, 32'hCAFE_0001);

    // Misaligned and unmapped accesses
    do_op(0, 1, 2'b01, 0, 32'h1000_0001, 0, st, rd, ms, rq);
    chk("t5_mis", 32'({ms, rq}), 32'b10);
    chk("t5_mis_stall", st, 0);
    do_op(0, 1, 2'b10, 0, 32'hF000_0000, 0, st, rd, ms, rq);
    chk("t5_unmapped", 32'({rq, st[0]}), 0);
    chk("t5_unmapped_data", rd, 0);

    // Reset while draining discards buffered stores
    idle(1);
    gnt_mode = 0;
    for (int i = 0; i < 3; i++)
      do_op(1, 0, 2'b10, 0, 32'h1000_0040 + 32'(4 * i), $urandom, st, rd, ms, rq);
    #1; we = 1'b0;
    @(negedge clk); #1;
    chk("t6_req_before", 32'(req), 1);
    rst = 1'b1; #1;
    chk("t6_req_reset", 32'(req), 0);
    bus_q.delete(); rd_q.delete(); smem.delete(); rmem.delete();
    gnt_mode = 1;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
    do_op(0, 1, 2'b10, 0, 32'h1000_0040, 0, st, rd, ms, rq);
    chk("t6_empty_after", st, 0);

    // Randomized traffic with random grants
    gnt_mode = 2;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      a = {nibs[$urandom_range(0, 6)], 23'h0, 5'($urandom_range(0, 31))};
      h = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 4) != 0) a = (h == 2'b10) ? {a[31:2], 2'b00} : (h == 2'b01) ? {a[31:1], 1'b0} : a;
      if (r < 4)      do_op(1, 0, h, 0, a, $urandom, st, rd, ms, rq);
      else if (r < 8) do_op(0, 1, h, 1'($urandom_range(0, 1)), a, 0, st, rd, ms, rq);
      else            idle(1);
    end
    gnt_mode = 1;
    idle(20);
    chk("end_bus_q", 32'(bus_q.size()), 0);
    chk("end_rd_q", 32'(rd_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
